// File: rtl/serial_adder_n.sv
// Bit-serial adder: one full-adder slice reused over WIDTH cycles, with a start/busy/done handshake.
// Define SERIAL_ADDER_N_SUB_EN to add a 'sub' port that selects a - b (cout=1 means no borrow).
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_N_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] load_b;
  logic             load_c;
  logic [1:0]       fa;

  // Two half adders plus an OR; returns {carry, sum}.
  function automatic logic [1:0] fa_slice(input logic x, input logic y, input logic ci);
    logic s1, c1, c2;
    s1 = x ^ y;
    c1 = x & y;
    c2 = s1 & ci;
    return {c1 | c2, s1 ^ ci};
  endfunction

  always_comb begin
    load_b = b;
    load_c = cin;
`ifdef SERIAL_ADDER_N_SUB_EN
    // Two's-complement subtract: invert b and force the initial carry.
    if (sub) begin
      load_b = ~b;
      load_c = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    fa      = fa_slice(a_sh_q[0], b_sh_q[0], carry_q);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = load_b;
          carry_d = load_c;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = {fa[0], acc_q[WIDTH-1:1]};
        carry_d = fa[1];
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        // Only the final slice publishes to sum/cout; partial shifts stay internal.
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = {fa[0], acc_q[WIDTH-1:1]};
          cout_d  = fa[1];
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised bit-serial adder. It is the sequential successor of the team's single-bit half/full adder cells.
- Adds two WIDTH-bit operands plus carry-in using one full-adder slice (two half adders plus an OR), reused over WIDTH clock cycles.
- Has a start/busy/done handshake. Sits in the lab datapath wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled on the rising edge of clk.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while the addition is in progress.
- done  output  1  single-cycle pulse marking that sum and cout are valid.
- sum  output  WIDTH  result bits, registered.
- cout  output  1  carry-out, registered.

Behaviour:
- Reset: rst high forces the following immediately, without waiting for clk:
  - state to IDLE;
  - busy=0, done=0, sum=0, cout=0;
  - bit counter, operand shift registers and carry flop cleared.
- States:
  - IDLE: waiting for start.
  - RUN: processing one bit per cycle.
  - DONE: result presented; lasts exactly one cycle.
- IDLE -> RUN: start=1 at edge E0. At E0:
  - a and b load into the shift registers;
  - cin loads into the carry flop;
  - counter=0, busy=1.
- RUN, each edge E1..E_WIDTH:
  - Slice inputs are the operand LSBs and the carry flop.
  - The slice sum bit shifts into the result register MSB-first-in, so after WIDTH shifts bit 0 sits at the LSB.
  - The slice carry loads into the carry flop.
  - Both operand registers shift right and the counter increments.
- RUN -> DONE: at edge E_WIDTH (counter reaches WIDTH-1 before that edge):
  - sum and cout take their final values;
  - busy=0, done=1.
- DONE, next edge:
  - done returns to 0.
  - If start=1 on that edge: operands are accepted, the block goes to RUN, busy=1 (back-to-back operation, no idle bubble needed).
  - Otherwise: go to IDLE.
- Latency: done rises exactly WIDTH cycles after the start edge. Throughput: one result per WIDTH+1 cycles.
- sum and cout:
  - Only change when a computation completes. Intermediate shift values are internal and must not appear on sum.
  - The last result is held through IDLE and through the next RUN until the next DONE.
- start while busy=1: ignored. Operands and cin are not re-captured and the current operation is unaffected.
- Changes on a, b or cin after the start edge have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Exact for all inputs, including all-ones operands with cin=1.
- Reset during RUN: the operation is abandoned with no done pulse, and all outputs go to their reset values.
- rst deassertion: synchronous to clk at the system level. The block needs no extra handling of deassertion.

Optional Feature:
- Macro SERIAL_ADDER_N_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured on the start edge.
  - sub=1 computes a - b: b is inverted into the shift register and the carry flop is loaded with 1; cin is ignored.
  - cout=1 means no borrow (a >= b, unsigned).
  - sub=0 behaves exactly like the base block.
- When undefined: there is no sub port, and add-only behaviour is unchanged.

Test Plan:
- Reset, WIDTH=8: assert rst mid-cycle -> busy/done/sum/cout all 0 immediately, with no clk edge required.
- a=8'h35, b=8'h4A, cin=0, one-cycle start -> busy high for 8 cycles; done pulses at start edge +8; sum=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Ignored inputs:
  - Start 8'h10+8'h20; pulse start with a=8'hAA at cycle 3 -> ignored, result sum=8'h30.
  - Also change a and b during RUN -> result still 8'h30.
- Back-to-back: hold start=1 across DONE with 8'h01+8'h02, then 8'h03+8'h04 -> done pulses 9 cycles apart; sum 8'h03 then 8'h07; sum holds 8'h03 between the two pulses.
- Reset mid-run: assert rst at cycle 4 of RUN -> no done pulse, outputs 0. Next start 8'h0F+8'h01 -> sum=8'h10.
- Subtraction (SERIAL_ADDER_N_SUB_EN defined):
  - sub=1, a=8'h10, b=8'h20 -> sum=8'hF0, cout=0.
  - sub=1, a=8'h20, b=8'h10 -> sum=8'h10, cout=1.
